// File: rtl/uart_tx.sv
// UART transmitter: pulls WIDTH-bit words from a FIFO and sends 8N1-style
// frames (start, WIDTH data bits LSB first, stop) with a registered tx line.
module uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_MAX  = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    baud_q, baud_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             rd_en_q, rd_en_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            rd_en_q <= rd_en_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = FETCH;
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d = fifo_dout;
                bit_d   = '0;
                baud_d  = '0;
                state_d = START;
            end
            START: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            DATA: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_MAX) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            STOP: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        rd_en_d = (state_d == FETCH);
        done_d  = (state_d == STOP) && (baud_d == BAUD_MAX);
    end

    assign tx         = tx_q;
    assign fifo_rd_en = rd_en_q;
    assign tx_done    = done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx with a queue FIFO and a frame-level timing
// model that predicts tx/busy/fifo_rd_en/tx_done on every cycle.
module tb_uart_tx;

    localparam int W     = 8;
    localparam int C     = 4;
    localparam int FRAME = (W + 2) * C;
    localparam int MAXC  = 2048;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         fifo_empty = 1'b1;
    logic [W-1:0] fifo_dout = '0;
    logic         fifo_rd_en;
    logic         tx;
    logic         busy;
    logic         tx_done;

    logic [W-1:0] fq[$];
    logic [3:0]   exp_v[MAXC];
    int           n_tests = 0;
    int           n_fail = 0;
    int           bad_reads = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .WIDTH(W),
        .CLKS_PER_BIT(C)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .tx(tx),
        .busy(busy),
        .tx_done(tx_done)
    );

    // FIFO with registered data and registered empty flag.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fq.size() == 0) bad_reads <= bad_reads + 1;
            else fifo_dout <= fq.pop_front();
        end
        fifo_empty <= (fq.size() == 0);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {tx,busy,rd_en,tx_done} per sample after words are pushed.
    // Sample 1 is IDLE (empty flag lag), FETCH at 2, LOAD at 3, then the
    // frame; consecutive words are separated by one IDLE cycle.
    task automatic build(input logic [W-1:0] ws[$], input int len);
        int t;
        int bi;
        logic [W-1:0] w;
        logic lvl;
        for (int i = 0; i < len; i++) exp_v[i] = 4'b1000;
        t = 2;
        foreach (ws[k]) begin
            w = ws[k];
            exp_v[t]     = 4'b1110;
            exp_v[t + 1] = 4'b1100;
            for (int j = 0; j < FRAME; j++) begin
                bi = j / C;
                if (bi == 0) lvl = 1'b0;
                else if (bi <= W) lvl = w[bi - 1];
                else lvl = 1'b1;
                exp_v[t + 2 + j] = {lvl, 1'b1, 1'b0, (j == FRAME - 1)};
            end
            t += 3 + FRAME;
        end
    endtask

    task automatic send(input logic [W-1:0] ws[$], input string name);
        int len;
        int rd_cnt;
        int done_cnt;
        int busy_cnt;
        logic [3:0] v;
        len = 2 + ws.size() * (3 + FRAME) + 8;
        rd_cnt = 0;
        done_cnt = 0;
        busy_cnt = 0;
        build(ws, len);
        @(negedge clk);
        foreach (ws[k]) fq.push_back(ws[k]);
        for (int i = 1; i < len; i++) begin
            @(negedge clk);
            v = {tx, busy, fifo_rd_en, tx_done};
            check($sformatf("%s@%0d", name, i), v, exp_v[i]);
            rd_cnt += int'(fifo_rd_en);
            done_cnt += int'(tx_done);
            busy_cnt += int'(busy);
        end
        check({name, "_rd"}, rd_cnt, ws.size());
        check({name, "_done"}, done_cnt, ws.size());
        check({name, "_busy"}, busy_cnt, ws.size() * (2 + FRAME));
        check({name, "_fifo"}, fq.size(), 0);
    endtask

    initial begin
        logic [W-1:0] ws[$];
        int cnt;

        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_rd", fifo_rd_en, 0);
        check("rst_done", tx_done, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check($sformatf("idle@%0d", i), {tx, busy, fifo_rd_en, tx_done},
                  4'b1000);
        end

        ws = {8'hA5};
        send(ws, "a5");
        ws = {8'h00, 8'hFF};
        send(ws, "b2b");

        // Abort mid-frame during data bit 3 of 0x3C.
        ws = {8'h3C};
        build(ws, 64);
        @(negedge clk);
        fq.push_back(8'h3C);
        repeat (21) @(negedge clk);
        check("pre_abort", {tx, busy, fifo_rd_en, tx_done}, exp_v[21]);
        reset_n = 1'b0;
        #1;
        check("abort", {tx, busy, fifo_rd_en, tx_done}, 4'b1000);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cnt += int'(busy) + int'(fifo_rd_en) + int'(tx_done) + int'(!tx);
        end
        check("post_abort_quiet", cnt, 0);
        check("post_abort_fifo", fq.size(), 0);

        ws.delete();
        for (int i = 0; i < 16; i++) ws.push_back(W'(i));
        send(ws, "seq16");

        for (int b = 0; b < 6; b++) begin
            ws.delete();
            repeat ($urandom_range(1, 3)) ws.push_back(W'($urandom));
            send(ws, $sformatf("rnd%0d", b));
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        check("reads_while_empty", bad_reads, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
